// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: owns the 3x3 board, validates moves, detects
// win/draw/timeout and drives the state/turn pair consumed by the turn timer.
module ttt_game_ctrl #(
  parameter logic [3:0] INIT_TIME = 4'd9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        move_valid,
  input  logic [3:0]  move_pos,
  input  logic [3:0]  count,
  output logic [2:0]  state,
  output logic [1:0]  turn,
  output logic [3:0]  initial_time,
  output logic [17:0] board,
  output logic        move_ack,
  output logic        move_err
);

  typedef enum logic [2:0] {
    S_INIT = 3'b000,
    S_PLAY = 3'b001,
    S_AWIN = 3'b010,
    S_BWIN = 3'b011,
    S_DRAW = 3'b100
  } state_e;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P_A    = 2'b01;
  localparam logic [1:0] P_B    = 2'b10;

  state_e      state_q, state_d;
  logic [1:0]  turn_q, turn_d;
  logic [17:0] board_q, board_d;
  logic [3:0]  moves_q, moves_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic        cell_empty;
  logic        legal;
  logic [17:0] board_mv;
  logic [3:0]  moves_inc;

  function automatic logic line_won(input logic [17:0] b, input logic [1:0] p,
                                    input int unsigned c0, input int unsigned c1,
                                    input int unsigned c2);
    return (b[2*c0 +: 2] == p) && (b[2*c1 +: 2] == p) && (b[2*c2 +: 2] == p);
  endfunction

  function automatic logic has_win(input logic [17:0] b, input logic [1:0] p);
    return line_won(b, p, 0, 1, 2) || line_won(b, p, 3, 4, 5) ||
           line_won(b, p, 6, 7, 8) || line_won(b, p, 0, 3, 6) ||
           line_won(b, p, 1, 4, 7) || line_won(b, p, 2, 5, 8) ||
           line_won(b, p, 0, 4, 8) || line_won(b, p, 2, 4, 6);
  endfunction

  // Decode the addressed cell without indexing past bit 17 for positions 9..15.
  always_comb begin
    cell_empty = 1'b0;
    board_mv   = board_q;
    for (int i = 0; i < 9; i++) begin
      if (move_pos == 4'(i)) begin
        cell_empty        = (board_q[2*i +: 2] == P_NONE);
        board_mv[2*i +: 2] = turn_q;
      end
    end
  end

  assign legal     = move_valid && (move_pos <= 4'd8) && cell_empty;
  assign moves_inc = moves_q + 4'd1;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    board_d = board_q;
    moves_d = moves_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_PLAY: begin
        if (legal) begin
          board_d = board_mv;
          ack_d   = 1'b1;
          moves_d = moves_inc;
          if (has_win(board_mv, turn_q)) begin
            state_d = (turn_q == P_A) ? S_AWIN : S_BWIN;
            turn_d  = P_NONE;
          end else if (moves_inc == 4'd9) begin
            state_d = S_DRAW;
            turn_d  = P_NONE;
          end else begin
            turn_d  = (turn_q == P_A) ? P_B : P_A;
          end
        end else begin
          err_d = move_valid;
          if (count == 4'd0) begin
            state_d = (turn_q == P_A) ? S_BWIN : S_AWIN;
            turn_d  = P_NONE;
          end
        end
      end
      S_INIT, S_AWIN, S_BWIN, S_DRAW: begin
        if (start) begin
          state_d = S_PLAY;
          turn_d  = P_A;
          board_d = '0;
          moves_d = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        turn_d  = P_NONE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      turn_q  <= P_NONE;
      board_q <= '0;
      moves_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      board_q <= board_d;
      moves_q <= moves_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign state        = state_q;
  assign turn         = turn_q;
  assign board        = board_q;
  assign move_ack     = ack_q;
  assign move_err     = err_q;
  assign initial_time = INIT_TIME;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed table-driven bench for ttt_game_ctrl, plus hand-written sequences
// for asynchronous reset and a move held across several cycles.
module tb_ttt_game_ctrl;

  localparam logic [2:0] INIT = 3'b000, PLAY = 3'b001, AWIN = 3'b010,
                         BWIN = 3'b011, DRAW = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        move_valid;
  logic [3:0]  move_pos;
  logic [3:0]  count;
  logic [2:0]  state;
  logic [1:0]  turn;
  logic [3:0]  initial_time;
  logic [17:0] board;
  logic        move_ack;
  logic        move_err;

  ttt_game_ctrl #(.INIT_TIME(4'd9)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .move_valid   (move_valid),
    .move_pos     (move_pos),
    .count        (count),
    .state        (state),
    .turn         (turn),
    .initial_time (initial_time),
    .board        (board),
    .move_ack     (move_ack),
    .move_err     (move_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        mv;
    logic [3:0]  pos;
    logic [3:0]  cnt;
    logic [2:0]  e_state;
    logic [1:0]  e_turn;
    logic [17:0] e_board;
    logic        e_ack;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic st, input logic mv, input logic [3:0] pos,
                     input logic [3:0] cnt, input logic [2:0] es, input logic [1:0] et,
                     input logic [17:0] eb, input logic ea, input logic ee);
    vec_t v;
    v.st = st; v.mv = mv; v.pos = pos; v.cnt = cnt;
    v.e_state = es; v.e_turn = et; v.e_board = eb; v.e_ack = ea; v.e_err = ee;
    vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic st, input logic mv, input logic [3:0] pos,
                      input logic [3:0] cnt);
    @(negedge clk);
    start = st; move_valid = mv; move_pos = pos; count = cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] es, input logic [1:0] et,
                           input logic [17:0] eb, input logic ea, input logic ee);
    check({tag, ".state"}, 32'(state), 32'(es));
    check({tag, ".turn"},  32'(turn),  32'(et));
    check({tag, ".board"}, 32'(board), 32'(eb));
    check({tag, ".ack"},   32'(move_ack), 32'(ea));
    check({tag, ".err"},   32'(move_err), 32'(ee));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; move_valid = 1'b0; move_pos = '0; count = 4'd9;
    #3;
    check_all("reset", INIT, 2'b00, 18'h0, 1'b0, 1'b0);
    check("initial_time", 32'(initial_time), 32'd9);
    #10 rst_n = 1'b1;

    // INIT ignores moves.
    add(0, 1, 4'd0, 9, INIT, 2'b00, 18'h0,     0, 0);
    // Row win A0,B3,A1,B4,A2.
    add(1, 0, 4'd0, 9, PLAY, 2'b01, 18'h0,     0, 0);
    add(0, 1, 4'd0, 9, PLAY, 2'b10, 18'h1,     1, 0);
    add(0, 1, 4'd3, 9, PLAY, 2'b01, 18'h81,    1, 0);
    add(0, 1, 4'd1, 9, PLAY, 2'b10, 18'h85,    1, 0);
    add(0, 1, 4'd4, 9, PLAY, 2'b01, 18'h285,   1, 0);
    add(0, 1, 4'd2, 9, AWIN, 2'b00, 18'h295,   1, 0);
    // Terminal state ignores moves and count.
    add(0, 1, 4'd5, 0, AWIN, 2'b00, 18'h295,   0, 0);
    // Illegal moves: occupied cell, then out-of-range position.
    add(1, 0, 4'd0, 9, PLAY, 2'b01, 18'h0,     0, 0);
    add(0, 1, 4'd4, 9, PLAY, 2'b10, 18'h100,   1, 0);
    add(0, 1, 4'd4, 9, PLAY, 2'b10, 18'h100,   0, 1);
    add(0, 1, 4'd12, 9, PLAY, 2'b10, 18'h100,  0, 1);
    add(0, 0, 4'd0, 9, PLAY, 2'b10, 18'h100,   0, 0);
    // start with a move in PLAY: start ignored, move processed.
    add(1, 1, 4'd0, 9, PLAY, 2'b01, 18'h102,   1, 0);
    // A times out -> BWIN on the edge sampling count==0.
    add(0, 0, 4'd0, 3, PLAY, 2'b01, 18'h102,   0, 0);
    add(0, 0, 4'd0, 2, PLAY, 2'b01, 18'h102,   0, 0);
    add(0, 0, 4'd0, 1, PLAY, 2'b01, 18'h102,   0, 0);
    add(0, 0, 4'd0, 0, BWIN, 2'b00, 18'h102,   0, 0);
    // start in BWIN; draw A0,B1,A2,B4,A3,B5,A7,B6,A8.
    add(1, 0, 4'd0, 9, PLAY, 2'b01, 18'h0,     0, 0);
    add(0, 1, 4'd0, 9, PLAY, 2'b10, 18'h1,     1, 0);
    add(0, 1, 4'd1, 9, PLAY, 2'b01, 18'h9,     1, 0);
    add(0, 1, 4'd2, 9, PLAY, 2'b10, 18'h19,    1, 0);
    add(0, 1, 4'd4, 9, PLAY, 2'b01, 18'h219,   1, 0);
    add(0, 1, 4'd3, 9, PLAY, 2'b10, 18'h259,   1, 0);
    add(0, 1, 4'd5, 9, PLAY, 2'b01, 18'hA59,   1, 0);
    add(0, 1, 4'd7, 9, PLAY, 2'b10, 18'h4A59,  1, 0);
    add(0, 1, 4'd6, 9, PLAY, 2'b01, 18'h6A59,  1, 0);
    add(0, 1, 4'd8, 9, DRAW, 2'b00, 18'h16A59, 1, 0);
    // Legal move with count==0 wins priority; then B times out -> AWIN.
    add(1, 0, 4'd0, 9, PLAY, 2'b01, 18'h0,     0, 0);
    add(0, 1, 4'd4, 0, PLAY, 2'b10, 18'h100,   1, 0);
    add(0, 0, 4'd0, 0, AWIN, 2'b00, 18'h100,   0, 0);
    // Win on the ninth move: A0,B1,A2,B4,A3,B5,A7,B8,A6.
    add(1, 0, 4'd0, 9, PLAY, 2'b01, 18'h0,     0, 0);
    add(0, 1, 4'd0, 9, PLAY, 2'b10, 18'h1,     1, 0);
    add(0, 1, 4'd1, 9, PLAY, 2'b01, 18'h9,     1, 0);
    add(0, 1, 4'd2, 9, PLAY, 2'b10, 18'h19,    1, 0);
    add(0, 1, 4'd4, 9, PLAY, 2'b01, 18'h219,   1, 0);
    add(0, 1, 4'd3, 9, PLAY, 2'b10, 18'h259,   1, 0);
    add(0, 1, 4'd5, 9, PLAY, 2'b01, 18'hA59,   1, 0);
    add(0, 1, 4'd7, 9, PLAY, 2'b10, 18'h4A59,  1, 0);
    add(0, 1, 4'd8, 9, PLAY, 2'b01, 18'h24A59, 1, 0);
    add(0, 1, 4'd6, 9, AWIN, 2'b00, 18'h25A59, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].st, vecs[i].mv, vecs[i].pos, vecs[i].cnt);
      check_all($sformatf("v%0d", i), vecs[i].e_state, vecs[i].e_turn,
                vecs[i].e_board, vecs[i].e_ack, vecs[i].e_err);
    end

    // Asynchronous reset mid-game with a non-empty board, away from any edge.
    step(1, 0, 4'd0, 9);
    step(0, 1, 4'd0, 9);
    check_all("pre_rst", PLAY, 2'b10, 18'h1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", INIT, 2'b00, 18'h0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step(1, 0, 4'd0, 9);
    check_all("rst_start", PLAY, 2'b01, 18'h0, 1'b0, 1'b0);

    // A move held for several cycles: accepted once, then rejected.
    step(0, 1, 4'd0, 9);
    check_all("hold1", PLAY, 2'b10, 18'h1, 1'b1, 1'b0);
    step(0, 1, 4'd0, 9);
    check_all("hold2", PLAY, 2'b10, 18'h1, 1'b0, 1'b1);
    step(0, 1, 4'd0, 9);
    check_all("hold3", PLAY, 2'b10, 18'h1, 1'b0, 1'b1);
    step(0, 0, 4'd0, 9);
    check_all("hold_end", PLAY, 2'b10, 18'h1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Game controller for the tic-tac-toe design: owns the 3x3 board, validates player moves, detects win/draw, and drives the `state`/`turn` pair consumed by the turn countdown timer. It is the other end of the timer interface. It produces `state`, `turn` and the reload value `initial_time`, and consumes the timer's `count` to detect a turn timeout.

## Interface
- `INIT_TIME`, default 4'd9: per-turn time budget, driven unchanged on `initial_time`.
- `clk`  in  1  system clock, all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  start a new game; honoured in INIT and terminal states, ignored in PLAY.
- `move_valid`  in  1  a move request is present this cycle.
- `move_pos`  in  4  cell index 0..8, row-major (0 = top-left, 8 = bottom-right).
- `count`  in  4  remaining time from the countdown timer.
- `state`  out  3  INIT=3'b000, PLAY=3'b001, AWIN=3'b010, BWIN=3'b011, DRAW=3'b100.
- `turn`  out  2  2'b01 = player A, 2'b10 = player B, 2'b00 outside PLAY.
- `initial_time`  out  4  constant `INIT_TIME`.
- `board`  out  18  cell i at bits [2i+1:2i]; 2'b00 = empty, 2'b01 = A, 2'b10 = B.
- `move_ack`  out  1  one-cycle pulse: the move was accepted.
- `move_err`  out  1  one-cycle pulse: the move was rejected.

## Operation
- Reset (async, rst_n=0) values: state=INIT, turn=00, board=0, move_ack=0, move_err=0, move counter=0.
- INIT:
  - `start` -> PLAY, board cleared, turn=A, move counter=0.
  - `move_valid` is ignored; no ack and no err.
- PLAY: a move is legal when `move_pos` <= 8 and the addressed cell is 00.
  - Legal move: write the current player's code into the cell, pulse `move_ack`, increment the move counter (4-bit, 0..9).
  - Same edge, evaluate the updated board over the 8 lines (3 rows, 3 cols, 2 diagonals).
  - If the mover completes a line -> AWIN or BWIN; turn=00.
  - Else if the move counter reaches 9 -> DRAW; turn=00.
  - Else turn flips (01<->10). The flip is the timer's reload trigger.
  - Illegal move (pos 9..15 or occupied cell): pulse `move_err`; board, turn and state are unchanged.
  - Timeout: `count` == 0 with no legal move in the same cycle -> the opponent of `turn` wins (A times out -> BWIN, B times out -> AWIN); turn=00.
  - `start` is ignored.
- AWIN/BWIN/DRAW:
  - Board and state hold.
  - Moves are ignored (no ack, no err).
  - `start` -> PLAY with board cleared, turn=A, counter=0.
- Priority in PLAY: legal move > timeout. A legal move in the same cycle as `count`==0 is accepted and its result stands; no timeout is taken that cycle.
- A win on the 9th move is reported as a win, not DRAW.

## Timing
- All outputs are registered.
- Every effect appears at the rising edge that samples the input; there is no extra latency.
- `move_ack`/`move_err` are high for exactly one cycle after the sampling edge. They are never both high.
- A move held on `move_valid` for N cycles is evaluated every cycle. After acceptance the cell is occupied, so the following cycles produce `move_err`.
- `turn` changes only on an accepted non-terminal move, on entry to PLAY, or on entry to a terminal state.
- `count` is only examined in PLAY. Values on `count` in other states have no effect.
- Reset asserted mid-game returns to INIT immediately and asynchronously; all outputs take their reset values without waiting for `clk`.

## Test plan
- Reset/start:
  - Drive rst_n=0 mid-PLAY with a non-empty board -> state=000, turn=00, board=0 without a clock edge.
  - Then `start` -> state=001, turn=01.
- Row win:
  - Moves A0, B3, A1, B4, A2 -> five `move_ack` pulses.
  - After the last edge: state=010, turn=00, board=18'b00_00_00_00_10_10_01_01_01.
- Illegal moves:
  - In PLAY with A at cell 4, B plays pos 4 -> `move_err`=1 for one cycle, turn stays 10, board unchanged.
  - Then pos 12 -> `move_err` again, no state change.
- Timeout:
  - A to move, `count` driven 3,2,1,0 with no move -> state=011 (BWIN) on the edge sampling 0.
  - Repeat with B to move -> 010.
- Draw:
  - Sequence A0,B1,A2,B4,A3,B5,A7,B6,A8 -> nine acks, final state=100, no win flagged.
- Simultaneous events:
  - Legal move while `count`==0 -> move accepted, turn flips, no timeout.
  - `start` and `move_valid` in PLAY -> start ignored, move processed.
  - `start` in BWIN -> PLAY, board=0, turn=01.
